dsp_mac_sequencer: RTL

- Upstream controller for the DSP48A1 slice. Accepts a stream of (sample, coefficient) pairs over a valid/ready handshake and drives the slice's A, B, opmode and a common clock enable so the slice computes an NTAPS-term dot product in its P accumulator.
- Tracks the slice pipeline latency, captures the final P, and presents it on an output valid/ready port.
- All slice stalls are done with the shared clock enable, so the slice pipeline and the sequencer's opmode delay line always advance together.

---
 rtl/dsp_mac_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dsp_mac_sequencer.sv
// Sequencer feeding a DSP48A1 slice an NTAPS-term dot product through a shared
// clock enable, then capturing P and offering it on a valid/ready result port.
module dsp_mac_sequencer #(
    parameter int NTAPS      = 8,
    parameter int PIPE_LAT   = 3,
    parameter int OPMODE_DLY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_sample,
    input  logic [17:0] s_coef,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    input  logic [47:0] dsp_p,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data,
    output logic        busy,
    output logic [7:0]  tap_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FEED    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

    localparam logic [7:0] OP_RESTART = 8'h01;
    localparam logic [7:0] OP_ACCUM   = 8'h09;
    localparam logic [7:0] LAST_TAP   = 8'(NTAPS - 1);
    localparam logic [3:0] LAST_DRAIN = 4'(PIPE_LAT - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic        s_ready_r;
    logic        m_valid_r;
    logic [47:0] m_data_r;
    logic [7:0]  tap_cnt_r;
    logic [3:0]  drain_cnt_r;
    logic        accept_s;
    logic        ce_s;
    logic [7:0]  slot_op_s;

    assign accept_s = s_valid & s_ready_r;

    // Next-state decode plus the slice enable and the opmode of the current slot.
    always_comb begin
        state_next_s = state_r;
        ce_s         = 1'b0;
        slot_op_s    = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    ce_s         = 1'b1;
                    slot_op_s    = OP_RESTART;
                    state_next_s = ST_FEED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (accept_s) begin
                    ce_s      = 1'b1;
                    slot_op_s = OP_ACCUM;
                    if (tap_cnt_r == LAST_TAP) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_FEED;
                    end
                end else begin
                    state_next_s = ST_FEED;
                end
            end
            ST_DRAIN: begin
                ce_s      = 1'b1;
                slot_op_s = OP_ACCUM;
                if (drain_cnt_r == LAST_DRAIN) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_CAPTURE: begin
                state_next_s = ST_OUT;
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake, tap and drain bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            s_ready_r   <= 1'b0;
            m_valid_r   <= 1'b0;
            m_data_r    <= 48'd0;
            tap_cnt_r   <= 8'd0;
            drain_cnt_r <= 4'd0;
        end else begin
            state_r   <= state_next_s;
            // The IDLE cycle right after a result handshake keeps s_ready low,
            // giving frames a one-cycle gap and a registered ready.
            s_ready_r <= (state_r != ST_OUT) &&
                         ((state_next_s == ST_IDLE) || (state_next_s == ST_FEED));
            m_valid_r <= (state_next_s == ST_OUT);
            if (state_r == ST_CAPTURE) begin
                m_data_r <= dsp_p;
            end
            if (accept_s) begin
                tap_cnt_r <= (tap_cnt_r == LAST_TAP) ? 8'd0 : tap_cnt_r + 8'd1;
            end
            drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + 4'd1 : 4'd0;
        end
    end

    generate
        if (OPMODE_DLY == 0) begin : g_op_direct
            assign dsp_opmode = ce_s ? slot_op_s : 8'h00;
        end else begin : g_op_delay
            logic [7:0] op_dly_r [OPMODE_DLY];

            // Opmode delay line; shifts only with the slice enable.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < OPMODE_DLY; i++) begin
                        op_dly_r[i] <= 8'h00;
                    end
                end else if (ce_s) begin
                    op_dly_r[0] <= slot_op_s;
                    for (int i = 1; i < OPMODE_DLY; i++) begin
                        op_dly_r[i] <= op_dly_r[i-1];
                    end
                end
            end

            assign dsp_opmode = op_dly_r[OPMODE_DLY-1];
        end
    endgenerate

    assign s_ready = s_ready_r;
    assign dsp_a   = accept_s ? s_sample : 18'd0;
    assign dsp_b   = accept_s ? s_coef : 18'd0;
    assign dsp_ce  = ce_s;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign busy    = (state_r != ST_IDLE);
    assign tap_cnt = tap_cnt_r;

endmodule
